// File: rtl/alu_seq_pkg.sv
// alu_op_sequencer shared types: ALU opcodes and sequencer FSM states.
// Optional op counter is enabled with ALU_SEQ_OPCNT_EN.
package alu_seq_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Operand register file: three async read ports, two write ports.
// Writeback beats host write on an address collision.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int PART_LEN = 8,
  parameter int REG_AW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_AW-1:0]     ra_addr,
  output logic [2*PART_LEN-1:0] ra_data,
  input  logic [REG_AW-1:0]     rb_addr,
  output logic [2*PART_LEN-1:0] rb_data,
  input  logic [REG_AW-1:0]     rh_addr,
  output logic [2*PART_LEN-1:0] rh_data,
  input  logic                  wb_en,
  input  logic [REG_AW-1:0]     wb_addr,
  input  logic [2*PART_LEN-1:0] wb_data,
  input  logic                  hw_en,
  input  logic [REG_AW-1:0]     hw_addr,
  input  logic [2*PART_LEN-1:0] hw_data
);

  localparam int REG_CNT = 2**REG_AW;
  localparam int DW      = 2*PART_LEN;

  logic [DW-1:0] mem [REG_CNT];

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
  assign rh_data = mem[rh_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_CNT; i++) begin
        if (wb_en && wb_addr == REG_AW'(i)) begin
          mem[i] <= wb_data;
        end else if (hw_en && hw_addr == REG_AW'(i)) begin
          mem[i] <= hw_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/writeback sequencer for the 2xPART_LEN ALU: IDLE-READ-EXEC-WB.
// Define ALU_SEQ_OPCNT_EN to add the 16-bit op_count output.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PART_LEN = 8,
  parameter int REG_AW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [REG_AW-1:0]     cmd_src_a,
  input  logic [REG_AW-1:0]     cmd_src_b,
  input  logic [REG_AW-1:0]     cmd_dst,
  input  logic                  wr_en,
  input  logic [REG_AW-1:0]     wr_addr,
  input  logic [2*PART_LEN-1:0] wr_data,
  input  logic [REG_AW-1:0]     rd_addr,
  output logic [2*PART_LEN-1:0] rd_data,
  output logic [2*PART_LEN-1:0] alu_a,
  output logic [2*PART_LEN-1:0] alu_b,
  output logic [1:0]            alu_ctrl,
  input  logic [2*PART_LEN-1:0] alu_res,
  output logic                  busy,
  output logic                  done,
  output logic [2*PART_LEN-1:0] done_data
`ifdef ALU_SEQ_OPCNT_EN
  ,
  output logic [15:0]           op_count
`endif
);

  localparam int DW = 2*PART_LEN;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              wb_en;
  logic [1:0]        op_q;
  logic [REG_AW-1:0] src_a_q;
  logic [REG_AW-1:0] src_b_q;
  logic [REG_AW-1:0] dst_q;
  logic [DW-1:0]     ra_data;
  logic [DW-1:0]     rb_data;
  logic [DW-1:0]     result_q;

  alu_seq_regfile #(
    .PART_LEN (PART_LEN),
    .REG_AW   (REG_AW)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (src_a_q),
    .ra_data (ra_data),
    .rb_addr (src_b_q),
    .rb_data (rb_data),
    .rh_addr (rd_addr),
    .rh_data (rd_data),
    .wb_en   (wb_en),
    .wb_addr (dst_q),
    .wb_data (result_q),
    .hw_en   (wr_en),
    .hw_addr (wr_addr),
    .hw_data (wr_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    wb_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        wb_en     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // ALU inputs only move in READ so the ALU sees stable operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      result_q  <= '0;
      done      <= 1'b0;
      done_data <= '0;
    end else begin
      done <= wb_en;
      if (accept) begin
        op_q    <= cmd_op;
        src_a_q <= cmd_src_a;
        src_b_q <= cmd_src_b;
        dst_q   <= cmd_dst;
      end
      if (state == S_READ) begin
        alu_a    <= ra_data;
        alu_b    <= rb_data;
        alu_ctrl <= op_q;
      end
      if (state == S_EXEC) begin
        result_q <= alu_res;
      end
      if (wb_en) begin
        done_data <= result_q;
      end
    end
  end

`ifdef ALU_SEQ_OPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (wb_en) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU
// and a register-file reference model; optional op_count checked too.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [2:0]    cmd_src_a;
  logic [2:0]    cmd_src_b;
  logic [2:0]    cmd_dst;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_ctrl;
  logic [DW-1:0] alu_res;
  logic          busy;
  logic          done;
  logic [DW-1:0] done_data;
`ifdef ALU_SEQ_OPCNT_EN
  logic [15:0]   op_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] mdl [8];
  int mdl_cnt = 0;

  alu_op_sequencer #(.PART_LEN(8), .REG_AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_src_a (cmd_src_a),
    .cmd_src_b (cmd_src_b),
    .cmd_dst   (cmd_dst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_res   (alu_res),
    .busy      (busy),
    .done      (done),
    .done_data (done_data)
`ifdef ALU_SEQ_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU the sequencer drives.
  always_comb begin
    if (alu_ctrl[1]) alu_res = alu_ctrl[0] ? alu_a - alu_b : alu_a + alu_b;
    else alu_res = alu_a * alu_b;
  end

  function automatic logic [DW-1:0] alu_ref(input logic [1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      2'b10:   return a + b;
      2'b11:   return a - b;
      default: return a * b;
    endcase
  endfunction

  // Model: host write on E0 is visible to the read, later ones are not;
  // writeback is applied last so it wins a same-address collision.
  task automatic mdl_cmd(input logic [1:0] op, input logic [2:0] a, b, d,
                         input int ph, input logic [2:0] wa,
                         input logic [DW-1:0] wd, output logic [DW-1:0] exp);
    if (ph == 0) mdl[wa] = wd;
    exp = alu_ref(op, mdl[a], mdl[b]);
    if (ph >= 1) mdl[wa] = wd;
    mdl[d] = exp;
    mdl_cnt++;
  endtask

  task automatic host_write(input logic [2:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); @(negedge clk);
    wr_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [DW-1:0] v);
    rd_addr = a;
    #1 v = rd_data;
  endtask

  // Issue one command; optional host write lands on edge E<ph>.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, b, d,
                         input int ph, input logic [2:0] wa,
                         input logic [DW-1:0] wd,
                         output logic [DW-1:0] got, output int lat,
                         output int busy_n, output logic done_after);
    cmd_valid = 1'b1; cmd_op = op;
    cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    if (ph == 0) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; busy_n = 0;
    while (!done && lat < 10) begin
      if (lat == ph) wr_en = 1'b0;
      if (lat == ph - 1) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; end
      if (busy) busy_n++;
      @(negedge clk); lat++;
    end
    wr_en = 1'b0;
    got = done_data;
    @(negedge clk);
    done_after = done;
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || done_data !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_out busy=%b done=%b done_data=%h want 0/0/0000",
               busy, done, done_data);
    end
    n_cmp++;
    if (alu_a !== 16'h0 || alu_b !== 16'h0 || alu_ctrl !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_alu a=%h b=%h ctrl=%b want 0", alu_a, alu_b, alu_ctrl);
    end
    rst_n = 1'b1;
    @(negedge clk);
    read_reg(3'd5, v);
    n_cmp++;
    if (cmd_ready !== 1'b1 || v !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_release cmd_ready=%b r5=%h want 1/0000", cmd_ready, v);
    end
  endtask

  task automatic test_add();
    logic [DW-1:0] got, exp, v;
    int lat, bn;
    logic da;
    host_write(3'd1, 16'h0003);
    host_write(3'd2, 16'h0005);
    mdl_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, -1, 3'd0, '0, exp);
    run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, -1, 3'd0, '0, got, lat, bn, da);
    n_cmp++;
    if (got !== 16'h0008) begin
      n_bad++; $display("FAIL add_result got=%h want 0008", got);
    end
    n_cmp++;
    if (lat !== 3 || bn !== 3 || da !== 1'b0) begin
      n_bad++;
      $display("FAIL add_timing lat=%0d busy=%0d done_after=%b want 3/3/0",
               lat, bn, da);
    end
    read_reg(3'd3, v);
    n_cmp++;
    if (v !== 16'h0008) begin
      n_bad++; $display("FAIL add_rd r3=%h want 0008", v);
    end
  endtask

  task automatic test_sub_wrap();
    logic [DW-1:0] got, exp, v;
    int lat, bn;
    logic da;
    mdl_cmd(OP_SUB, 3'd1, 3'd2, 3'd4, -1, 3'd0, '0, exp);
    run_cmd(OP_SUB, 3'd1, 3'd2, 3'd4, -1, 3'd0, '0, got, lat, bn, da);
    read_reg(3'd4, v);
    n_cmp++;
    if (got !== 16'hFFFE || v !== 16'hFFFE) begin
      n_bad++; $display("FAIL sub_wrap done_data=%h r4=%h want FFFE", got, v);
    end
  endtask

  task automatic test_mul_inplace();
    logic [DW-1:0] got, exp, v;
    int lat, bn;
    logic da;
    host_write(3'd5, 16'h0004);
    host_write(3'd6, 16'h0003);
    mdl_cmd(OP_MUL, 3'd5, 3'd6, 3'd5, -1, 3'd0, '0, exp);
    run_cmd(OP_MUL, 3'd5, 3'd6, 3'd5, -1, 3'd0, '0, got, lat, bn, da);
    read_reg(3'd5, v);
    n_cmp++;
    if (v !== 16'h000C || got !== 16'h000C) begin
      n_bad++; $display("FAIL mul_inplace r5=%h done_data=%h want 000C", v, got);
    end
    n_cmp++;
    if (alu_a !== 16'h0004) begin
      n_bad++; $display("FAIL mul_hold alu_a=%h want 0004", alu_a);
    end
    mdl_cmd(2'b01, 3'd5, 3'd6, 3'd7, -1, 3'd0, '0, exp);
    run_cmd(2'b01, 3'd5, 3'd6, 3'd7, -1, 3'd0, '0, got, lat, bn, da);
    n_cmp++;
    if (alu_ctrl !== 2'b01 || got !== 16'h0024) begin
      n_bad++;
      $display("FAIL op01_mul ctrl=%b res=%h want 01/0024", alu_ctrl, got);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] got, exp, v, w;
    int lat, bn;
    logic da;
    mdl_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 3, 3'd3, 16'h1234, exp);
    run_cmd(OP_ADD, 3'd1, 3'd2, 3'd3, 3, 3'd3, 16'h1234, got, lat, bn, da);
    read_reg(3'd3, v);
    n_cmp++;
    if (v !== 16'h0008) begin
      n_bad++; $display("FAIL collide_wb r3=%h want 0008", v);
    end
    host_write(3'd3, 16'h1234);
    read_reg(3'd3, v);
    n_cmp++;
    if (v !== 16'h1234) begin
      n_bad++; $display("FAIL collide_host r3=%h want 1234", v);
    end
    mdl_cmd(OP_SUB, 3'd2, 3'd1, 3'd6, 3, 3'd7, 16'hBEEF, exp);
    run_cmd(OP_SUB, 3'd2, 3'd1, 3'd6, 3, 3'd7, 16'hBEEF, got, lat, bn, da);
    read_reg(3'd6, v);
    read_reg(3'd7, w);
    n_cmp++;
    if (v !== 16'h0002 || w !== 16'hBEEF) begin
      n_bad++; $display("FAIL both_writes r6=%h r7=%h want 0002/BEEF", v, w);
    end
  endtask

  task automatic test_host_race();
    logic [DW-1:0] got, exp;
    int lat, bn;
    logic da;
    mdl_cmd(OP_ADD, 3'd1, 3'd2, 3'd0, 0, 3'd1, 16'h0020, exp);
    run_cmd(OP_ADD, 3'd1, 3'd2, 3'd0, 0, 3'd1, 16'h0020, got, lat, bn, da);
    n_cmp++;
    if (got !== 16'h0025) begin
      n_bad++; $display("FAIL race_e0 got=%h want 0025", got);
    end
    mdl_cmd(OP_ADD, 3'd1, 3'd2, 3'd0, 1, 3'd2, 16'h0100, exp);
    run_cmd(OP_ADD, 3'd1, 3'd2, 3'd0, 1, 3'd2, 16'h0100, got, lat, bn, da);
    n_cmp++;
    if (got !== 16'h0025) begin
      n_bad++; $display("FAIL race_e1 got=%h want 0025", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e1, e2;
    int lat, ctrl_bad;
    cmd_valid = 1'b1; cmd_op = OP_ADD;
    cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd0;
    @(posedge clk); @(negedge clk);
    mdl_cmd(OP_ADD, 3'd1, 3'd2, 3'd0, -1, 3'd0, '0, e1);
    cmd_op = OP_SUB; cmd_src_a = 3'd0; cmd_src_b = 3'd1; cmd_dst = 3'd4;
    lat = 0; ctrl_bad = 0;
    while (!done && lat < 10) begin
      if (lat >= 1 && alu_ctrl !== OP_ADD) ctrl_bad++;
      @(negedge clk); lat++;
    end
    n_cmp++;
    if (lat !== 3 || ctrl_bad !== 0 || alu_ctrl !== OP_ADD || done_data !== e1) begin
      n_bad++;
      $display("FAIL b2b_first lat=%0d ctrl_bad=%0d res=%h want 3/0/%h",
               lat, ctrl_bad, done_data, e1);
    end
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept busy=%b want 1", busy);
    end
    cmd_valid = 1'b0;
    mdl_cmd(OP_SUB, 3'd0, 3'd1, 3'd4, -1, 3'd0, '0, e2);
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clk); lat++;
    end
    n_cmp++;
    if (lat !== 3 || done_data !== e2) begin
      n_bad++;
      $display("FAIL b2b_second lat=%0d res=%h want 3/%h", lat, done_data, e2);
    end
`ifdef ALU_SEQ_OPCNT_EN
    n_cmp++;
    if (op_count !== 16'(mdl_cnt)) begin
      n_bad++; $display("FAIL op_count got=%0d want %0d", op_count, mdl_cnt);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DW-1:0] got, exp, v;
    logic [1:0] op;
    logic [2:0] a, b, d, wa;
    logic [DW-1:0] wd;
    int ph, lat, bn;
    logic da;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        host_write(3'($urandom_range(0, 7)), 16'($urandom));
      op = 2'($urandom); a = 3'($urandom); b = 3'($urandom);
      d = 3'($urandom); wa = 3'($urandom); wd = 16'($urandom);
      ph = int'($urandom_range(0, 4)) - 1;
      mdl_cmd(op, a, b, d, ph, wa, wd, exp);
      run_cmd(op, a, b, d, ph, wa, wd, got, lat, bn, da);
      n_cmp++;
      if (got !== exp || lat !== 3 || da !== 1'b0) begin
        n_bad++;
        $display("FAIL rand_%0d res=%h lat=%0d da=%b want %h/3/0",
                 i, got, lat, da, exp);
      end
      read_reg(wa, v);
      n_cmp++;
      if (v !== mdl[wa]) begin
        n_bad++; $display("FAIL rand_rd_%0d r%0d=%h want %h", i, wa, v, mdl[wa]);
      end
    end
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), v);
      n_cmp++;
      if (v !== mdl[r]) begin
        n_bad++; $display("FAIL readback r%0d=%h want %h", r, v, mdl[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] v;
    int seen;
    host_write(3'd2, 16'h00AA);
    cmd_valid = 1'b1; cmd_op = OP_ADD;
    cmd_src_a = 3'd2; cmd_src_b = 3'd2; cmd_dst = 3'd1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid busy=%b ready=%b done=%b want 0/1/0",
               busy, cmd_ready, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    mdl_cnt = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_cmp++;
    if (seen !== 0 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_no_done seen=%0d ready=%b want 0/1", seen, cmd_ready);
    end
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), v);
      n_cmp++;
      if (v !== mdl[r]) begin
        n_bad++; $display("FAIL rst_clear r%0d=%h want %h", r, v, mdl[r]);
      end
    end
    n_cmp++;
    if (done_data !== 16'h0 || alu_a !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_regs done_data=%h alu_a=%h want 0", done_data, alu_a);
    end
`ifdef ALU_SEQ_OPCNT_EN
    n_cmp++;
    if (op_count !== 16'h0) begin
      n_bad++; $display("FAIL rst_op_count got=%0d want 0", op_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_mul_inplace();
    test_collision();
    test_host_race();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
